poker_stream_eval: RTL and testbench



---
 rtl/poker_pkg.sv | 34 +++
 rtl/poker_stream_eval_classify.sv | 74 +++++++
 rtl/poker_stream_eval.sv | 163 ++++++++++++++++
 tb/tb_poker_stream_eval.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// Shared definitions for the streaming five-card poker evaluator:
// hand-class encodings, card/rank constants, FSM state type and the
// helper that maps a (suit, rank) card onto its seen-bitmap position.
package poker_pkg;

  localparam logic [3:0] TYPE_SF    = 4'b1000;
  localparam logic [3:0] TYPE_FOUR  = 4'b0111;
  localparam logic [3:0] TYPE_FULL  = 4'b0110;
  localparam logic [3:0] TYPE_FLUSH = 4'b0101;
  localparam logic [3:0] TYPE_STR   = 4'b0100;
  localparam logic [3:0] TYPE_THREE = 4'b0011;
  localparam logic [3:0] TYPE_TWOP  = 4'b0010;
  localparam logic [3:0] TYPE_PAIR  = 4'b0001;
  localparam logic [3:0] TYPE_HIGH  = 4'b0000;
  localparam logic [3:0] TYPE_ERR   = 4'b1111;

  localparam logic [3:0] RANK_A    = 4'd1;
  localparam logic [3:0] RANK_K    = 4'd13;
  localparam int         HAND_SIZE = 5;
  localparam int         NUM_RANKS = 13;
  localparam int         NUM_CARDS = 52;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    OUT     = 2'd2
  } state_e;

  // Bitmap position suit*13 + rank-1; only meaningful for ranks A..K.
  function automatic logic [5:0] seen_index(input logic [1:0] suit, input logic [3:0] rank);
    return ({4'd0, suit} * 6'd13) + {2'd0, rank} - 6'd1;
  endfunction

endpackage

// File: rtl/poker_stream_eval_classify.sv
// Purely combinational hand classifier.
// Ports:
//   rank_cnt_i : per-rank card counts, index 0 = ace ... 12 = king
//   flush_i    : all five suits matched
//   err_flag_i : invalid or duplicate card seen; overrides every class
//   type_o     : 4-bit hand class
module poker_classify
  import poker_pkg::*;
#(
  parameter bit ACE_LOW_EN = 1'b0
) (
  input  logic [NUM_RANKS-1:0][2:0] rank_cnt_i,
  input  logic                      flush_i,
  input  logic                      err_flag_i,
  output logic [3:0]                type_o
);

  logic [2:0] pairs_s;
  logic       has3_s, has4_s, distinct_s, wheel_s, broadway_s, straight_s;
  logic [3:0] min_idx_s, max_idx_s;

  // Histogram scan: pair/trip/quad detection and lowest/highest occupied rank.
  always_comb begin
    pairs_s    = 3'd0;
    has3_s     = 1'b0;
    has4_s     = 1'b0;
    distinct_s = 1'b1;
    min_idx_s  = 4'd0;
    max_idx_s  = 4'd0;
    for (int i = 0; i < NUM_RANKS; i++) begin
      pairs_s    = pairs_s + 3'((rank_cnt_i[i] == 3'd2));
      has3_s     = has3_s | (rank_cnt_i[i] == 3'd3);
      has4_s     = has4_s | (rank_cnt_i[i] == 3'd4);
      distinct_s = distinct_s & (rank_cnt_i[i] <= 3'd1);
      if (rank_cnt_i[i] != 3'd0) begin
        max_idx_s = 4'(i);
      end else begin
        max_idx_s = max_idx_s;
      end
    end
    for (int i = NUM_RANKS - 1; i >= 0; i--) begin
      if (rank_cnt_i[i] != 3'd0) begin
        min_idx_s = 4'(i);
      end else begin
        min_idx_s = min_idx_s;
      end
    end
  end

  assign wheel_s = (rank_cnt_i[0] == 3'd1) && (rank_cnt_i[1] == 3'd1) &&
                   (rank_cnt_i[2] == 3'd1) && (rank_cnt_i[3] == 3'd1) &&
                   (rank_cnt_i[4] == 3'd1);
  assign broadway_s = (rank_cnt_i[0] == 3'd1) && (rank_cnt_i[9] == 3'd1) &&
                      (rank_cnt_i[10] == 3'd1) && (rank_cnt_i[11] == 3'd1) &&
                      (rank_cnt_i[12] == 3'd1);
  // A-2-3-4-5 naturally spans 4, so the ace-low mode has to explicitly veto it when disabled.
  assign straight_s = distinct_s &&
                      ((((max_idx_s - min_idx_s) == 4'd4) && (ACE_LOW_EN || !wheel_s)) || broadway_s);

  // Priority ladder from error down to high card.
  always_comb begin
    if (err_flag_i)                      type_o = TYPE_ERR;
    else if (straight_s && flush_i)      type_o = TYPE_SF;
    else if (has4_s)                     type_o = TYPE_FOUR;
    else if (has3_s && pairs_s != 3'd0)  type_o = TYPE_FULL;
    else if (flush_i)                    type_o = TYPE_FLUSH;
    else if (straight_s)                 type_o = TYPE_STR;
    else if (has3_s)                     type_o = TYPE_THREE;
    else if (pairs_s >= 3'd2)            type_o = TYPE_TWOP;
    else if (pairs_s == 3'd1)            type_o = TYPE_PAIR;
    else                                 type_o = TYPE_HIGH;
  end

endmodule

// File: rtl/poker_stream_eval.sv
// Streaming five-card poker evaluator. Cards arrive one per cycle over a
// valid/ready stream, are accumulated into a rank histogram, a suit-match
// flag and a seen-card bitmap, classified in one EVAL cycle, and the result
// is held until the downstream handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : card stream handshake
//   card                 : [5:4] suit, [3:0] rank (1 = A ... 13 = K)
//   out_valid / out_ready: result handshake
//   hand_type            : hand class (the name "type" is a reserved word)
//   err                  : hand contained an invalid rank or duplicate card
//   hand_cnt             : number of results accepted downstream (wraps)
module poker_stream_eval
  import poker_pkg::*;
#(
  parameter bit          ACE_LOW_EN = 1'b0,
  parameter int unsigned HAND_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            card,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            hand_type,
  output logic                  err,
  output logic [HAND_CNT_W-1:0] hand_cnt
);

  state_e                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [NUM_RANKS-1:0][2:0] rank_cnt_q, rank_cnt_d;
  logic [NUM_CARDS-1:0]      seen_q, seen_d;
  logic [1:0]                suit0_q, suit0_d;
  logic                      flush_q, flush_d;
  logic                      err_flag_q, err_flag_d;
  logic [3:0]                type_q, type_d;
  logic                      err_q, err_d;
  logic                      out_valid_q, out_valid_d;
  logic [HAND_CNT_W-1:0]     hand_cnt_q, hand_cnt_d;

  logic [3:0] rank_s;
  logic [1:0] suit_s;
  logic       rank_ok_s;
  logic [5:0] seen_idx_s;
  logic [3:0] class_type_s;

  assign rank_s     = card[3:0];
  assign suit_s     = card[5:4];
  assign rank_ok_s  = (rank_s >= RANK_A) && (rank_s <= RANK_K);
  assign seen_idx_s = seen_index(suit_s, rank_s);

  poker_classify #(.ACE_LOW_EN(ACE_LOW_EN)) u_classify (
    .rank_cnt_i (rank_cnt_q),
    .flush_i    (flush_q),
    .err_flag_i (err_flag_q),
    .type_o     (class_type_s)
  );

  // Next-state and accumulator update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rank_cnt_d  = rank_cnt_q;
    seen_d      = seen_q;
    suit0_d     = suit0_q;
    flush_d     = flush_q;
    err_flag_d  = err_flag_q;
    type_d      = type_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    hand_cnt_d  = hand_cnt_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          // Out-of-range ranks still count toward the five cards but never touch the histogram.
          if (!rank_ok_s) begin
            err_flag_d = 1'b1;
          end else if (seen_q[seen_idx_s]) begin
            err_flag_d = 1'b1;
          end else begin
            seen_d[seen_idx_s]        = 1'b1;
            rank_cnt_d[rank_s - 4'd1] = rank_cnt_q[rank_s - 4'd1] + 3'd1;
          end
          if (idx_q == 3'd0) begin
            suit0_d = suit_s;
            flush_d = 1'b1;
          end else begin
            flush_d = flush_q & (suit_s == suit0_q);
          end
          if (idx_q == 3'(HAND_SIZE - 1)) begin
            idx_d   = 3'd0;
            state_d = EVAL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      EVAL: begin
        type_d      = class_type_s;
        err_d       = err_flag_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          hand_cnt_d  = hand_cnt_q + HAND_CNT_W'(1);
          rank_cnt_d  = '0;
          seen_d      = '0;
          flush_d     = 1'b0;
          err_flag_d  = 1'b0;
          idx_d       = 3'd0;
          state_d     = COLLECT;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= 3'd0;
      rank_cnt_q  <= '0;
      seen_q      <= '0;
      suit0_q     <= 2'd0;
      flush_q     <= 1'b0;
      err_flag_q  <= 1'b0;
      type_q      <= 4'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      hand_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rank_cnt_q  <= rank_cnt_d;
      seen_q      <= seen_d;
      suit0_q     <= suit0_d;
      flush_q     <= flush_d;
      err_flag_q  <= err_flag_d;
      type_q      <= type_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      hand_cnt_q  <= hand_cnt_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = out_valid_q;
  assign hand_type = type_q;
  assign err       = err_q;
  assign hand_cnt  = hand_cnt_q;

endmodule

// File: tb/tb_poker_stream_eval.sv
// Directed bench: two instances (ace-low off / on) see identical card
// streams; expected classes are hand-computed per hand.
module tb_poker_stream_eval;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] card = 6'd0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, err0;
  logic [3:0] type0;
  logic [7:0] hand_cnt0;
  logic       in_ready1, out_valid1, err1;
  logic [3:0] type1;
  logic [7:0] hand_cnt1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] hcnt = 8'd0;

  always #5 clk = ~clk;

  poker_stream_eval #(.ACE_LOW_EN(1'b0), .HAND_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .card(card), .out_valid(out_valid0), .out_ready(out_ready),
    .hand_type(type0), .err(err0), .hand_cnt(hand_cnt0)
  );

  poker_stream_eval #(.ACE_LOW_EN(1'b1), .HAND_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .card(card), .out_valid(out_valid1), .out_ready(out_ready),
    .hand_type(type1), .err(err1), .hand_cnt(hand_cnt1)
  );

  function automatic logic [5:0] cd(input int s, input int r);
    return 6'((s << 4) | r);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send_card(input logic [5:0] c);
    card = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hand(input logic [5:0] a, b, c, d, e);
    send_card(a);
    send_card(b);
    send_card(c);
    send_card(d);
    send_card(e);
  endtask

  // Called #1 after the 5th accept; result must appear after exactly one more edge.
  task automatic wait_result(input string name, input logic [3:0] exp0, input logic [3:0] exp1,
                             input logic exp_err);
    int lat = 0;
    while (!out_valid0 && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 1);
    chk({name, "_valid1"}, out_valid1, 1'b1);
    chk({name, "_type0"}, type0, exp0);
    chk({name, "_type1"}, type1, exp1);
    chk({name, "_err0"}, err0, exp_err);
    chk({name, "_err1"}, err1, exp_err);
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hcnt++;
    chk({name, "_valid_clr"}, out_valid0, 1'b0);
    chk({name, "_ready"}, in_ready0, 1'b1);
    chk({name, "_cnt0"}, hand_cnt0, hcnt);
    chk({name, "_cnt1"}, hand_cnt1, hcnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hcnt = 8'd0;
    #2;
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_type", type0, 4'd0);
    chk("rst_err", err0, 1'b0);
    chk("rst_hand_cnt0", hand_cnt0, 8'd0);
    chk("rst_hand_cnt1", hand_cnt1, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Straight flush with explicit check that EVAL cycle shows no result yet.
    send_hand(cd(2,9), cd(2,10), cd(2,11), cd(2,12), cd(2,13));
    chk("sf_eval_no_valid", out_valid0, 1'b0);
    chk("sf_eval_not_ready", in_ready0, 1'b0);
    wait_result("sf9k", 4'b1000, 4'b1000, 1'b0);
    accept("sf9k");

    send_hand(cd(0,10), cd(1,11), cd(2,12), cd(3,13), cd(0,1));
    wait_result("broadway", 4'b0100, 4'b0100, 1'b0);
    accept("broadway");

    send_hand(cd(2,10), cd(2,11), cd(2,12), cd(2,13), cd(2,1));
    wait_result("royal", 4'b1000, 4'b1000, 1'b0);
    accept("royal");

    send_hand(cd(0,1), cd(1,2), cd(2,3), cd(3,4), cd(0,5));
    wait_result("wheel", 4'b0000, 4'b0100, 1'b0);
    accept("wheel");

    send_hand(cd(1,1), cd(1,2), cd(1,3), cd(1,4), cd(1,5));
    wait_result("wheel_suited", 4'b0101, 4'b1000, 1'b0);
    accept("wheel_suited");

    send_hand(cd(0,7), cd(1,7), cd(2,7), cd(0,13), cd(1,13));
    wait_result("full", 4'b0110, 4'b0110, 1'b0);
    accept("full");

    send_hand(cd(0,7), cd(1,7), cd(2,7), cd(3,7), cd(0,2));
    wait_result("quads", 4'b0111, 4'b0111, 1'b0);
    accept("quads");

    send_hand(cd(0,4), cd(1,4), cd(2,9), cd(3,9), cd(0,11));
    wait_result("twopair", 4'b0010, 4'b0010, 1'b0);
    accept("twopair");

    send_hand(cd(3,2), cd(3,5), cd(3,8), cd(3,11), cd(3,13));
    wait_result("flush", 4'b0101, 4'b0101, 1'b0);
    accept("flush");

    send_hand(cd(0,5), cd(1,5), cd(2,5), cd(3,9), cd(0,2));
    wait_result("trips", 4'b0011, 4'b0011, 1'b0);
    accept("trips");

    send_hand(cd(0,2), cd(1,3), cd(2,4), cd(3,5), cd(0,7));
    wait_result("gap", 4'b0000, 4'b0000, 1'b0);
    accept("gap");

    send_hand(cd(0,5), cd(0,5), cd(1,7), cd(2,9), cd(3,11));
    wait_result("dup", 4'b1111, 4'b1111, 1'b1);
    accept("dup");

    send_hand(cd(0,14), cd(1,3), cd(2,7), cd(3,9), cd(0,12));
    wait_result("rank14", 4'b1111, 4'b1111, 1'b1);
    accept("rank14");

    send_hand(cd(1,0), cd(1,3), cd(1,7), cd(1,9), cd(1,12));
    wait_result("rank0", 4'b1111, 4'b1111, 1'b1);
    accept("rank0");

    send_hand(cd(0,3), cd(1,3), cd(2,8), cd(3,10), cd(0,13));
    wait_result("clean_pair", 4'b0001, 4'b0001, 1'b0);
    accept("clean_pair");

    // Partial hand stalls with in_valid low.
    send_card(cd(0,2));
    send_card(cd(1,6));
    send_card(cd(2,9));
    repeat (5) @(posedge clk);
    #1;
    chk("partial_no_valid", out_valid0, 1'b0);
    chk("partial_ready", in_ready0, 1'b1);
    send_card(cd(3,11));
    send_card(cd(0,13));
    wait_result("partial_high", 4'b0000, 4'b0000, 1'b0);
    accept("partial_high");

    // Backpressure: result holds, cards offered in OUT are ignored.
    out_ready = 1'b0;
    send_hand(cd(0,7), cd(1,7), cd(2,7), cd(0,13), cd(1,13));
    wait_result("bp", 4'b0110, 4'b0110, 1'b0);
    for (int i = 0; i < 4; i++) begin
      card = cd(0,7);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_type", type0, 4'b0110);
      chk("bp_hold_valid", out_valid0, 1'b1);
      chk("bp_not_ready", in_ready0, 1'b0);
      chk("bp_cnt_hold", hand_cnt0, hcnt);
    end
    in_valid = 1'b0;
    accept("bp");
    send_hand(cd(0,7), cd(1,7), cd(2,8), cd(3,10), cd(0,12));
    wait_result("after_bp", 4'b0001, 4'b0001, 1'b0);
    accept("after_bp");

    // Reset mid-hand discards the accumulators.
    send_card(cd(0,5));
    send_card(cd(1,6));
    do_reset();
    send_hand(cd(0,5), cd(1,6), cd(2,8), cd(3,10), cd(0,12));
    wait_result("post_rst", 4'b0000, 4'b0000, 1'b0);
    accept("post_rst");

    // Reset in OUT.
    send_hand(cd(0,5), cd(1,6), cd(2,8), cd(3,10), cd(0,12));
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_out_ready", in_ready0, 1'b1);
    out_ready = 1'b1;

    // Counter wrap after 256 accepted hands.
    for (int n = 0; n < 256; n++) begin
      send_hand(cd(0,2), cd(1,6), cd(2,9), cd(3,11), cd(n % 4, 13));
      wait_result("wrap_hand", 4'b0000, 4'b0000, 1'b0);
      accept("wrap_hand");
    end
    chk("wrap_cnt0", hand_cnt0, 8'd0);
    chk("wrap_cnt1", hand_cnt1, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
